elastic_pipe: RTL and testbench

ELASTIC_PIPE -- requirements
Module: elastic_pipe

---
 rtl/elastic_pipe_if.sv | 22 ++
 rtl/elastic_pipe.sv | 82 ++++++++
 tb/tb_elastic_pipe.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/elastic_pipe_if.sv
// Valid/ready bundle for elastic_pipe: upstream word in, downstream word out.
// A word moves on a rising edge where valid & ready are both 1; valid must not depend on ready.
interface elastic_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/elastic_pipe.sv
// DEPTH-stage valid/ready register pipe with bubble collapsing, synchronous flush
// and a registered occupancy count.
module elastic_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    elastic_pipe_if.slave                bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] OCC_ONE = OW'(1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d   [DEPTH];
    logic [DEPTH:0]   r;
    logic [DEPTH-1:0] vin;
    logic [WIDTH-1:0] din [DEPTH];
    logic             in_hs;
    logic             out_hs;

    // A stage can take a word if it is empty or its successor is moving on.
    always_comb begin
        r        = '0;
        r[DEPTH] = bus.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r[k] = !v[k] | r[k+1];
        end
    end

    always_comb begin
        vin    = '0;
        din    = '{default: '0};
        vin[0] = bus.in_valid;
        din[0] = bus.in_data;
        for (int k = 1; k < DEPTH; k++) begin
            vin[k] = v[k-1];
            din[k] = d[k-1];
        end
    end

    assign bus.in_ready  = r[0] & !flush;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign in_hs         = bus.in_valid & bus.in_ready;
    assign out_hs        = bus.out_valid & bus.out_ready;

    // Data only loads alongside a valid word, so empty slots keep stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (r[k]) begin
                    v[k] <= vin[k];
                    if (vin[k]) begin
                        d[k] <= din[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_hs && !out_hs) begin
            occupancy <= occupancy + OCC_ONE;
        end else if (out_hs && !in_hs) begin
            occupancy <= occupancy - OCC_ONE;
        end
    end
endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe (WIDTH=4, DEPTH=2): directed vector table, async reset
// sequence, and a random streaming phase, all feeding one data scoreboard.
module tb_elastic_pipe;
    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush   = 1'b0;
    logic [OW-1:0] occupancy;

    elastic_pipe_if #(.WIDTH(WIDTH)) bus ();

    elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .bus      (bus),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             fl;
        logic             iv;
        logic [WIDTH-1:0] id;
        logic             ordy;
        logic             e_irdy;
        logic             e_ov;
        logic [WIDTH-1:0] e_od;
        logic [OW-1:0]    e_occ;
    } vec_t;

    vec_t             tbl[$];
    logic [WIDTH-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input string name, input logic fl, input logic iv, input logic [WIDTH-1:0] id,
                       input logic ordy, input logic e_irdy, input logic e_ov,
                       input logic [WIDTH-1:0] e_od, input int e_occ);
        vec_t t;
        t.name = name; t.fl = fl; t.iv = iv; t.id = id; t.ordy = ordy;
        t.e_irdy = e_irdy; t.e_ov = e_ov; t.e_od = e_od; t.e_occ = OW'(e_occ);
        tbl.push_back(t);
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
    endtask

    // Pop on a delivered word, then clear on flush or push the accepted word.
    task automatic sb_step(input string name, input logic accept);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL %s data: got word %0h, expected no word", name, bus.out_data);
            end else begin
                check({name, " data"}, 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
        end
        if (flush) exp_q.delete();
        else if (accept) exp_q.push_back(bus.in_data);
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, 1'b0);

        // Reset values without any clock edge, and in_ready follows !flush.
        #2;
        flush = 1'b1;
        #1;
        check("rst in_ready flush", 32'(bus.in_ready), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", 32'(bus.out_data), 32'd0);
        check("rst occupancy", 32'(occupancy), 32'd0);
        flush = 1'b0;
        #1;
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        //   name    fl iv id     ordy irdy ov od    occ
        add("s1a",   0, 1, 4'hA,  1,   1,   0, 4'h0, 0);
        add("s1b",   0, 0, 4'h0,  1,   1,   0, 4'h0, 1);
        add("s1c",   0, 0, 4'h0,  1,   1,   1, 4'hA, 1);
        add("s1d",   0, 0, 4'h0,  1,   1,   0, 4'hA, 0);
        add("st1",   0, 1, 4'h1,  1,   1,   0, 4'hA, 0);
        add("st2",   0, 1, 4'h2,  1,   1,   0, 4'hA, 1);
        add("st3",   0, 1, 4'h3,  1,   1,   1, 4'h1, 2);
        add("st4",   0, 1, 4'h4,  1,   1,   1, 4'h2, 2);
        add("st5",   0, 0, 4'h0,  1,   1,   1, 4'h3, 2);
        add("st6",   0, 0, 4'h0,  1,   1,   1, 4'h4, 1);
        add("st7",   0, 0, 4'h0,  1,   1,   0, 4'h4, 0);
        add("bp1",   0, 1, 4'h5,  0,   1,   0, 4'h4, 0);
        add("bp2",   0, 1, 4'h6,  0,   1,   0, 4'h4, 1);
        add("bp3",   0, 1, 4'h7,  0,   0,   1, 4'h5, 2);
        add("bp4",   0, 1, 4'h7,  0,   0,   1, 4'h5, 2);
        add("bp5",   0, 1, 4'h7,  1,   1,   1, 4'h5, 2);
        add("bp6",   0, 0, 4'h0,  1,   1,   1, 4'h6, 2);
        add("bp7",   0, 0, 4'h0,  1,   1,   1, 4'h7, 1);
        add("bp8",   0, 0, 4'h0,  1,   1,   0, 4'h7, 0);
        add("bc1",   0, 1, 4'h8,  0,   1,   0, 4'h7, 0);
        add("bc2",   0, 0, 4'h0,  0,   1,   0, 4'h7, 1);
        add("bc3",   0, 1, 4'h9,  0,   1,   1, 4'h8, 1);
        add("bc4",   0, 0, 4'h0,  0,   0,   1, 4'h8, 2);
        add("bc5",   0, 0, 4'h0,  1,   1,   1, 4'h8, 2);
        add("bc6",   0, 1, 4'h3,  0,   1,   1, 4'h9, 1);
        add("bc7",   0, 0, 4'h0,  0,   0,   1, 4'h9, 2);
        add("fl1",   1, 1, 4'hB,  0,   0,   1, 4'h9, 2);
        add("fl2",   0, 0, 4'h0,  0,   1,   0, 4'h9, 0);
        add("fl3",   1, 0, 4'h0,  1,   0,   0, 4'h9, 0);
        add("fo1",   0, 1, 4'hC,  0,   1,   0, 4'h9, 0);
        add("fo2",   0, 1, 4'hD,  0,   1,   0, 4'h9, 1);
        add("fo3",   1, 1, 4'hE,  1,   0,   1, 4'hC, 2);
        add("fo4",   0, 0, 4'h0,  1,   1,   0, 4'hC, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            #1;
            check({tbl[i].name, " in_ready"}, 32'(bus.in_ready), 32'(tbl[i].e_irdy));
            check({tbl[i].name, " out_valid"}, 32'(bus.out_valid), 32'(tbl[i].e_ov));
            check({tbl[i].name, " out_data"}, 32'(bus.out_data), 32'(tbl[i].e_od));
            check({tbl[i].name, " occupancy"}, 32'(occupancy), 32'(tbl[i].e_occ));
            sb_step(tbl[i].name, tbl[i].iv & tbl[i].e_irdy & !tbl[i].fl);
            @(posedge clk);
            #1;
        end
        check("table words left", 32'(exp_q.size()), 32'd0);

        // Fill to two words, then drop reset between edges.
        drive(1'b0, 1'b1, 4'h1, 1'b0);
        #1;
        sb_step("ar1", 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 4'h2, 1'b0);
        #1;
        sb_step("ar2", 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, '0, 1'b0);
        check("ar full occupancy", 32'(occupancy), 32'd2);
        check("ar full out_data", 32'(bus.out_data), 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar out_valid", 32'(bus.out_valid), 32'd0);
        check("ar out_data", 32'(bus.out_data), 32'd0);
        check("ar occupancy", 32'(occupancy), 32'd0);
        check("ar in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ar after edge out_valid", 32'(bus.out_valid), 32'd0);
        check("ar after edge occupancy", 32'(occupancy), 32'd0);

        // Random streaming: in_ready is 1 unless the pipe is full and stalled.
        for (int c = 0; c < 80; c++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0);
            #1;
            check("rnd occupancy", 32'(occupancy), 32'(exp_q.size()));
            check("rnd in_ready", 32'(bus.in_ready),
                  32'((exp_q.size() < DEPTH) || bus.out_ready));
            sb_step("rnd", bus.in_valid & bus.in_ready);
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < DEPTH + 2; c++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            #1;
            sb_step("drain", 1'b0);
            @(posedge clk);
            #1;
        end
        check("drain words left", 32'(exp_q.size()), 32'd0);
        check("drain occupancy", 32'(occupancy), 32'd0);
        check("drain out_valid", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
